// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// Holds the occupancy encoding, the packed control-bundle field offsets and the
// per-stage bubble control encodings. There are no ports.
package pipe_stage_elastic_pkg;

  // Number of entries the stage holds (skid variant can reach OccFull).
  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccMain  = 2'd1,
    OccFull  = 2'd2
  } occ_e;

  // Packed control bundle layout: {WB, M, EX} with EX in the low bits.
  localparam int unsigned JModeLsb = 0;
  localparam int unsigned JModeW   = 3;
  localparam int unsigned ExCtrlW  = 6;
  localparam int unsigned MCtrlLsb = ExCtrlW;
  localparam int unsigned MCtrlW   = 5;
  localparam int unsigned WbCtrlLsb = MCtrlLsb + MCtrlW;

  // J_Mode value meaning "no jump"; used so a bubble never redirects the PC.
  localparam logic [JModeW-1:0] JModeNone = 3'd7;

  // Bubble control for a 16-bit bundle: all enables low, J_Mode = none.
  localparam logic [15:0] BubbleCtrlIdEx = 16'(JModeNone) << JModeLsb;
  localparam logic [15:0] BubbleCtrlZero = 16'h0000;

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready handshake bundle carrying a control word and a data payload.
// Signals:
//   valid  - producer holds a valid word
//   ready  - consumer can accept this cycle
//   ctrl   - control bundle (CTRL_W bits)
//   data   - payload (DATA_W bits)
// Modports: master (producer side), slave (consumer side).
interface pipe_stage_elastic_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_elastic_entry_reg.sv
// One pipeline entry: valid bit plus control and data registers.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   clr_i   - synchronous clear (flush), same effect as rst
//   load_i  - capture ctrl_i/data_i and mark valid
//   drop_i  - mark empty (ignored when load_i is set)
//   ctrl_i, data_i   - word to capture
//   valid_o, ctrl_o, data_o - held entry
module pipe_stage_elastic_entry_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, flush-to-bubble
// and an optional two-entry skid buffer.
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   flush_i     - drop all held entries and the same-cycle input
//   in_if       - upstream handshake (slave): valid/ctrl/data in, ready out
//   out_if      - downstream handshake (master): valid/ctrl/data out, ready in
//   occupancy_o - held entries (0..2, or 0..1 when SKID=0)
// An empty output shows BUBBLE_CTRL and zero data so downstream never sees stale bits.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 16,
  parameter int unsigned       DATA_W      = 128,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  pipe_stage_elastic_if.slave  in_if,
  pipe_stage_elastic_if.master out_if,
  output logic [1:0]           occupancy_o
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  logic              main_load, main_drop, main_from_skid;
  logic              skid_load, skid_drop;
  logic              in_ready, accept, rel;
  occ_e              occ;

  always_comb begin
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    // Skid variant: ready comes straight from the skid valid flop, so there is
    // no combinational path from out_if.ready back to in_if.ready.
    in_ready = SKID ? !skid_valid : (!main_valid || out_if.ready);
    accept   = in_if.valid && in_ready;
    rel      = main_valid && out_if.ready;
    if (SKID) begin
      if (skid_valid) begin
        // FULL: input is blocked; on release the older skid word moves up.
        if (rel) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_drop      = 1'b1;
        end
      end else if (accept) begin
        if (!main_valid || rel) main_load = 1'b1;
        else                    skid_load = 1'b1;
      end else if (rel) begin
        main_drop = 1'b1;
      end
    end else begin
      if (accept)   main_load = 1'b1;
      else if (rel) main_drop = 1'b1;
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_if.ctrl;
  assign main_data_d = main_from_skid ? skid_data : in_if.data;

  pipe_stage_elastic_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush_i),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID) begin : g_skid
    pipe_stage_elastic_entry_reg #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush_i),
      .load_i  (skid_load),
      .drop_i  (skid_drop),
      .ctrl_i  (in_if.ctrl),
      .data_i  (in_if.data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

  // Skid is only ever filled while main is valid.
  always_comb begin
    if (skid_valid)      occ = OccFull;
    else if (main_valid) occ = OccMain;
    else                 occ = OccEmpty;
  end

  assign occupancy_o  = occ;
  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  assign out_if.ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign out_if.data  = main_valid ? main_data : '0;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance.
module tb_pipe_stage_elastic;

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] BUB = 16'h0007;

  logic clk = 1'b0;
  logic rst;
  logic s_flush, n_flush;
  logic [1:0] s_occ, n_occ;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) s_in ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) s_out ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) n_in ();
  pipe_stage_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) n_out ();

  pipe_stage_elastic #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .BUBBLE_CTRL (BUB),
    .SKID        (1'b1)
  ) dut_s (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (s_flush),
    .in_if       (s_in),
    .out_if      (s_out),
    .occupancy_o (s_occ)
  );

  pipe_stage_elastic #(
    .CTRL_W      (CW),
    .DATA_W      (DW),
    .BUBBLE_CTRL (BUB),
    .SKID        (1'b0)
  ) dut_n (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (n_flush),
    .in_if       (n_in),
    .out_if      (n_out),
    .occupancy_o (n_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [31:0] d);
    s_in.valid = v;
    s_in.data  = d;
    s_in.ctrl  = d[15:0] + 16'h0100;
  endtask

  task automatic drive_n(input logic v, input logic [31:0] d);
    n_in.valid = v;
    n_in.data  = d;
    n_in.ctrl  = d[15:0] + 16'h0100;
  endtask

  initial begin
    rst = 1'b1;
    s_flush = 1'b0;
    n_flush = 1'b0;
    drive_s(1'b0, 32'h0);
    drive_n(1'b0, 32'h0);
    s_out.ready = 1'b0;
    n_out.ready = 1'b0;

    // 1. reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_s_valid", {31'b0, s_out.valid}, 32'd0);
    chk("rst_s_ctrl", {16'b0, s_out.ctrl}, {16'b0, BUB});
    chk("rst_s_data", s_out.data, 32'd0);
    chk("rst_s_occ", {30'b0, s_occ}, 32'd0);
    chk("rst_s_ready", {31'b0, s_in.ready}, 32'd1);
    chk("rst_n_ctrl", {16'b0, n_out.ctrl}, {16'b0, BUB});
    chk("rst_n_ready", {31'b0, n_in.ready}, 32'd1);
    chk("rst_n_occ", {30'b0, n_occ}, 32'd0);

    // 2. stream 1..8 with downstream always ready, both variants
    s_out.ready = 1'b1;
    n_out.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_s(1'b1, 32'(i));
      drive_n(1'b1, 32'(i));
      step();
      chk("strm_s_data", s_out.data, 32'(i));
      chk("strm_s_ctrl", {16'b0, s_out.ctrl}, 32'(i) + 32'h100);
      chk("strm_s_occ", {30'b0, s_occ}, 32'd1);
      chk("strm_n_data", n_out.data, 32'(i));
      chk("strm_n_occ", {30'b0, n_occ}, 32'd1);
    end
    // Idle input with X payload must not leak to the output.
    s_in.valid = 1'b0;
    s_in.data  = 'x;
    s_in.ctrl  = 'x;
    drive_n(1'b0, 32'h0);
    step();
    chk("drain_s_valid", {31'b0, s_out.valid}, 32'd0);
    chk("drain_s_data", s_out.data, 32'd0);
    chk("drain_s_ctrl", {16'b0, s_out.ctrl}, {16'b0, BUB});
    chk("drain_s_occ", {30'b0, s_occ}, 32'd0);
    chk("drain_n_occ", {30'b0, n_occ}, 32'd0);

    // 3. skid fill with downstream stalled, then drain in order
    s_out.ready = 1'b0;
    drive_s(1'b1, 32'hA);
    step();
    chk("fill_a_occ", {30'b0, s_occ}, 32'd1);
    chk("fill_a_ready", {31'b0, s_in.ready}, 32'd1);
    drive_s(1'b1, 32'hB);
    step();
    chk("full_occ", {30'b0, s_occ}, 32'd2);
    chk("full_ready", {31'b0, s_in.ready}, 32'd0);
    chk("full_data", s_out.data, 32'hA);
    drive_s(1'b1, 32'hEE);  // must be refused while FULL
    step();
    chk("full_hold_data", s_out.data, 32'hA);
    chk("full_hold_occ", {30'b0, s_occ}, 32'd2);
    drive_s(1'b0, 32'h0);
    s_out.ready = 1'b1;
    #1;
    chk("ready_indep", {31'b0, s_in.ready}, 32'd0);
    step();
    chk("drain_b_data", s_out.data, 32'hB);
    chk("drain_b_ctrl", {16'b0, s_out.ctrl}, 32'h10B);
    chk("drain_b_occ", {30'b0, s_occ}, 32'd1);
    chk("drain_b_ready", {31'b0, s_in.ready}, 32'd1);
    step();
    chk("drain_e_valid", {31'b0, s_out.valid}, 32'd0);
    chk("drain_e_occ", {30'b0, s_occ}, 32'd0);

    // 4. flush while FULL with a valid input word C
    s_out.ready = 1'b0;
    drive_s(1'b1, 32'h21);
    step();
    drive_s(1'b1, 32'h22);
    step();
    chk("refill_occ", {30'b0, s_occ}, 32'd2);
    drive_s(1'b1, 32'hC);
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    drive_s(1'b0, 32'h0);
    s_out.ready = 1'b1;
    chk("flush_valid", {31'b0, s_out.valid}, 32'd0);
    chk("flush_ctrl", {16'b0, s_out.ctrl}, {16'b0, BUB});
    chk("flush_data", s_out.data, 32'd0);
    chk("flush_occ", {30'b0, s_occ}, 32'd0);
    chk("flush_ready", {31'b0, s_in.ready}, 32'd1);
    step();
    chk("flush_no_c", {31'b0, s_out.valid}, 32'd0);

    // 5. single-entry variant: combinational ready and accept+release
    n_out.ready = 1'b0;
    drive_n(1'b1, 32'hD);
    step();
    chk("n_d_data", n_out.data, 32'hD);
    chk("n_d_occ", {30'b0, n_occ}, 32'd1);
    chk("n_stall_ready", {31'b0, n_in.ready}, 32'd0);
    drive_n(1'b1, 32'hE);
    step();
    chk("n_hold_data", n_out.data, 32'hD);
    n_out.ready = 1'b1;
    #1;
    chk("n_comb_ready", {31'b0, n_in.ready}, 32'd1);
    step();
    chk("n_e_data", n_out.data, 32'hE);
    chk("n_e_occ", {30'b0, n_occ}, 32'd1);
    drive_n(1'b1, 32'hF);
    n_flush = 1'b1;
    step();
    n_flush = 1'b0;
    drive_n(1'b0, 32'h0);
    chk("n_flush_valid", {31'b0, n_out.valid}, 32'd0);
    chk("n_flush_ctrl", {16'b0, n_out.ctrl}, {16'b0, BUB});
    chk("n_flush_occ", {30'b0, n_occ}, 32'd0);
    step();
    chk("n_flush_no_f", {31'b0, n_out.valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
